// File: rtl/trig_seq_pkg.sv
// Shared types and default sizing for the encoder-driven trigger sequencer.
package trig_seq_pkg;

    localparam int unsigned NUM_CH_DEF = 2;
    localparam int unsigned CNT_W_DEF  = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/trig_channel.sv
// One trigger channel: latches its timing and frame gating at sequence start and
// produces a registered pulse from the shared sequence time.
module trig_channel
    import trig_seq_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             run_d_i,
    input  logic [CNT_W:0]   t_d_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] delay_i,
    input  logic [CNT_W-1:0] width_i,
    input  logic [CNT_W-1:0] frm_start_i,
    input  logic [CNT_W-1:0] frm_stop_i,
    input  logic [CNT_W-1:0] frame_idx_i,
    output logic             trig_o,
    output logic [CNT_W:0]   end_c_o
);

    localparam int unsigned TW = CNT_W + 1;

    logic           act_c;
    logic           act_q, act_d;
    logic [CNT_W:0] delay_q, delay_d;
    logic [CNT_W:0] stop_q, stop_d;
    logic           trig_q, trig_d;

    // Live config view, only consumed on the start cycle.
    assign act_c   = en_i & (frame_idx_i >= frm_start_i) & (frame_idx_i < frm_stop_i);
    assign end_c_o = act_c ? (TW'(delay_i) + TW'(width_i)) : '0;

    // Compare against the next time value so the pulse lands on t == delay.
    always_comb begin
        act_d   = act_q;
        delay_d = delay_q;
        stop_d  = stop_q;
        if (start_i) begin
            act_d   = act_c;
            delay_d = TW'(delay_i);
            stop_d  = TW'(delay_i) + TW'(width_i);
        end
        trig_d = run_d_i & act_d & (t_d_i >= delay_d) & (t_d_i < stop_d);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            act_q   <= 1'b0;
            delay_q <= '0;
            stop_q  <= '0;
            trig_q  <= 1'b0;
        end else begin
            act_q   <= act_d;
            delay_q <= delay_d;
            stop_q  <= stop_d;
            trig_q  <= trig_d;
        end
    end

    assign trig_o = trig_q;

endmodule

// File: rtl/trig_sequencer.sv
// Encoder-edge trigger sequencer with per-channel delay/width and frame gating.
// Optional OVERRUN_CNT_EN builds a saturating counter of edges dropped while running.
module trig_sequencer
    import trig_seq_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    enc_trig_i,
    input  logic [NUM_CH-1:0]       ch_en_i,
    input  logic [NUM_CH*CNT_W-1:0] ch_delay_i,
    input  logic [NUM_CH*CNT_W-1:0] ch_width_i,
    input  logic [CNT_W-1:0]        frame_len_i,
    input  logic [NUM_CH*CNT_W-1:0] frm_start_i,
    input  logic [NUM_CH*CNT_W-1:0] frm_stop_i,
    output logic [NUM_CH-1:0]       trig_out_o,
    output logic                    busy_o,
    output logic [CNT_W-1:0]        frame_idx_o,
    output logic [CNT_W-1:0]        overrun_cnt_o
);

    localparam int unsigned TW = CNT_W + 1;

    state_e           state_q, state_d;
    logic [CNT_W:0]   t_q, t_d;
    logic [CNT_W:0]   end_q, end_d;
    logic [CNT_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0] flen_q, flen_d;
    logic             prev_q;
    logic             busy_q;
    logic             edge_c, start_c, run_d_c;
    logic [CNT_W:0]   end_max_c, frame_nxt_c;
    logic [CNT_W-1:0] flen_eff_c;
    logic [CNT_W:0]   ch_end_c [NUM_CH];

    assign edge_c  = enc_trig_i & ~prev_q;
    assign start_c = edge_c & (state_q == ST_IDLE);
    assign run_d_c = (state_d == ST_RUN);

    // Sequence length: longest active channel, never shorter than one cycle.
    always_comb begin
        end_max_c = TW'(1);
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_end_c[c] > end_max_c) end_max_c = ch_end_c[c];
        end
    end

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        end_d       = end_q;
        frame_d     = frame_q;
        flen_d      = flen_q;
        flen_eff_c  = (flen_q == '0) ? CNT_W'(1) : flen_q;
        frame_nxt_c = TW'(frame_q) + TW'(1);
        case (state_q)
            ST_IDLE: begin
                if (edge_c) begin
                    state_d = ST_RUN;
                    t_d     = '0;
                    end_d   = end_max_c;
                    flen_d  = frame_len_i;
                end
            end
            ST_RUN: begin
                t_d = t_q + TW'(1);
                if (t_q == end_q - TW'(1)) begin
                    state_d = ST_IDLE;
                    frame_d = (frame_nxt_c >= TW'(flen_eff_c)) ? '0 : frame_nxt_c[CNT_W-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            end_q   <= TW'(1);
            frame_q <= '0;
            flen_q  <= '0;
            prev_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            end_q   <= end_d;
            frame_q <= frame_d;
            flen_q  <= flen_d;
            prev_q  <= enc_trig_i;
            busy_q  <= run_d_c;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        trig_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .start_i     (start_c),
            .run_d_i     (run_d_c),
            .t_d_i       (t_d),
            .en_i        (ch_en_i[c]),
            .delay_i     (ch_delay_i[c*CNT_W +: CNT_W]),
            .width_i     (ch_width_i[c*CNT_W +: CNT_W]),
            .frm_start_i (frm_start_i[c*CNT_W +: CNT_W]),
            .frm_stop_i  (frm_stop_i[c*CNT_W +: CNT_W]),
            .frame_idx_i (frame_q),
            .trig_o      (trig_out_o[c]),
            .end_c_o     (ch_end_c[c])
        );
    end

`ifdef OVERRUN_CNT_EN
    logic [CNT_W-1:0] ovr_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ovr_q <= '0;
        end else if (edge_c && (state_q == ST_RUN) && (ovr_q != '1)) begin
            ovr_q <= ovr_q + CNT_W'(1);
        end
    end

    assign overrun_cnt_o = ovr_q;
`else
    assign overrun_cnt_o = '0;
`endif

    assign busy_o      = busy_q;
    assign frame_idx_o = frame_q;

endmodule

// File: tb/tb_trig_sequencer.sv
// Directed bench for trig_sequencer: timing, frame gating, overrun, reset abort,
// degenerate configs, and a narrow-counter instance for the no-wrap end compare.
module tb_trig_sequencer;

    localparam int unsigned W  = 32;
    localparam int unsigned WB = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            enc_trig;
    logic [1:0]      ch_en;
    logic [2*W-1:0]  ch_delay, ch_width, frm_start, frm_stop;
    logic [W-1:0]    frame_len;
    logic [1:0]      trig_out;
    logic            busy;
    logic [W-1:0]    frame_idx, overrun_cnt;

    logic            b_enc;
    logic [0:0]      b_en;
    logic [WB-1:0]   b_delay, b_width, b_flen, b_fs, b_fe;
    logic [0:0]      b_trig;
    logic            b_busy;
    logic [WB-1:0]   b_frame, b_ovr;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_ovr;

    trig_sequencer #(.NUM_CH(2), .CNT_W(W)) dut (
        .clk_i(clk), .reset_i(reset), .enc_trig_i(enc_trig), .ch_en_i(ch_en),
        .ch_delay_i(ch_delay), .ch_width_i(ch_width), .frame_len_i(frame_len),
        .frm_start_i(frm_start), .frm_stop_i(frm_stop), .trig_out_o(trig_out),
        .busy_o(busy), .frame_idx_o(frame_idx), .overrun_cnt_o(overrun_cnt)
    );

    trig_sequencer #(.NUM_CH(1), .CNT_W(WB)) dut_b (
        .clk_i(clk), .reset_i(reset), .enc_trig_i(b_enc), .ch_en_i(b_en),
        .ch_delay_i(b_delay), .ch_width_i(b_width), .frame_len_i(b_flen),
        .frm_start_i(b_fs), .frm_stop_i(b_fe), .trig_out_o(b_trig),
        .busy_o(b_busy), .frame_idx_o(b_frame), .overrun_cnt_o(b_ovr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [1:0] en, input int d0, input int w0, input int d1,
                           input int w1, input int fs0, input int fe0, input int fs1,
                           input int fe1, input int flen);
        ch_en     = en;
        ch_delay  = {W'(d1), W'(d0)};
        ch_width  = {W'(w1), W'(w0)};
        frm_start = {W'(fs1), W'(fs0)};
        frm_stop  = {W'(fe1), W'(fe0)};
        frame_len = W'(flen);
    endtask

    // Raise enc_trig at k=0 and check trig/busy for k=1..nk; chN high for k in [sN,eN].
    task automatic run_seq(input string tag, input int nk, input int bz, input int s0,
                           input int e0, input int s1, input int e1, input int re_k);
        logic [1:0] exp_t;
        enc_trig = 1'b1;
        for (int k = 1; k <= nk; k++) begin
            step();
            if (k == 1) enc_trig = 1'b0;
            if (k == re_k) enc_trig = 1'b1;
            if (k == re_k + 2) enc_trig = 1'b0;
            exp_t[0] = (k >= s0) && (k <= e0);
            exp_t[1] = (k >= s1) && (k <= e1);
            chk($sformatf("%s.k%0d.trig", tag, k), 64'(trig_out), 64'(exp_t));
            chk($sformatf("%s.k%0d.busy", tag, k), 64'(busy), 64'(k <= bz));
        end
    endtask

    initial begin
        reset    = 1'b1;
        enc_trig = 1'b0;
        b_enc    = 1'b0;
        b_en     = 1'b1;
        b_delay  = 8'hF0;
        b_width  = 8'h20;
        b_flen   = 8'd2;
        b_fs     = 8'd0;
        b_fe     = 8'd2;
        set_cfg(2'b11, 6, 3, 3, 2, 0, 4, 0, 4, 4);
        repeat (3) step();
        chk("rst.trig", 64'(trig_out), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.frame", 64'(frame_idx), 64'd0);
        chk("rst.ovr", 64'(overrun_cnt), 64'd0);
        reset = 1'b0;
        step();

        // Basic timing: ch0 k=7..9, ch1 k=4..5, busy k=1..9.
        run_seq("t1", 11, 9, 7, 9, 4, 5, -1);
        chk("t1.frame", 64'(frame_idx), 64'd1);

        // Frame gating: ch1 only in frames 1 and 2.
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_cfg(2'b11, 6, 3, 3, 2, 0, 4, 1, 3, 4);
        step();
        for (int f = 0; f < 5; f++) begin
            chk($sformatf("t2.f%0d.frame", f), 64'(frame_idx), 64'(f % 4));
            if ((f % 4) == 1 || (f % 4) == 2)
                run_seq($sformatf("t2.f%0d", f), 10, 9, 7, 9, 4, 5, -1);
            else
                run_seq($sformatf("t2.f%0d", f), 10, 9, 7, 9, 1, 0, -1);
        end
        chk("t2.frame_end", 64'(frame_idx), 64'd1);

        // Edge during a 10-cycle sequence is ignored.
        set_cfg(2'b01, 7, 3, 0, 0, 0, 4, 0, 4, 4);
        run_seq("t3", 12, 10, 8, 10, 1, 0, 3);
`ifdef OVERRUN_CNT_EN
        exp_ovr = W'(1);
`else
        exp_ovr = W'(0);
`endif
        chk("t3.ovr", 64'(overrun_cnt), 64'(exp_ovr));
        chk("t3.frame", 64'(frame_idx), 64'd2);

        // Reset mid-pulse with enc_trig held high.
        set_cfg(2'b01, 2, 5, 0, 0, 0, 4, 0, 4, 4);
        enc_trig = 1'b1;
        repeat (4) step();
        chk("t4.pre.trig", 64'(trig_out), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t4.rst.trig", 64'(trig_out), 64'd0);
        chk("t4.rst.busy", 64'(busy), 64'd0);
        chk("t4.rst.frame", 64'(frame_idx), 64'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("t4.hold%0d.busy", k), 64'(busy), 64'd0);
            chk($sformatf("t4.hold%0d.trig", k), 64'(trig_out), 64'd0);
        end
        enc_trig = 1'b0;
        step();
        run_seq("t4.re", 9, 7, 3, 7, 1, 0, -1);
        chk("t4.frame", 64'(frame_idx), 64'd1);

        // Zero widths and delays with frame_len=0: one-cycle runs, frame stays 0.
        set_cfg(2'b11, 0, 0, 0, 0, 0, 4, 0, 4, 0);
        for (int r = 0; r < 3; r++) begin
            run_seq($sformatf("t5.r%0d", r), 3, 1, 1, 0, 1, 0, -1);
            chk($sformatf("t5.r%0d.frame", r), 64'(frame_idx), 64'd0);
        end

        // No enabled channel: still one cycle, frame advances.
        set_cfg(2'b00, 6, 3, 3, 2, 0, 4, 0, 4, 4);
        run_seq("t5.noact", 4, 1, 1, 0, 1, 0, -1);
        chk("t5.noact.frame", 64'(frame_idx), 64'd1);

        // Narrow instance: delay+width = 0x110 must not wrap at 8 bits.
        b_enc = 1'b1;
        for (int k = 1; k <= 274; k++) begin
            step();
            if (k == 1) b_enc = 1'b0;
            if (k == 1 || k == 16 || k == 240 || k == 241 || k == 272 || k == 273) begin
                chk($sformatf("t6.k%0d.trig", k), 64'(b_trig), 64'((k >= 241) && (k <= 272)));
                chk($sformatf("t6.k%0d.busy", k), 64'(b_busy), 64'(k <= 272));
            end
        end
        chk("t6.frame", 64'(b_frame), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
